multiplier_proj_axil_slave: RTL and testbench

AXI4-Lite register slave for the multiplier peripheral: it is the responder that the AXI master (VIP in simulation, processor in hardware) drives through the block-design wrapper. It exposes operand, control, status and 64-bit result registers. It also owns an iterative 32×32 unsigned shift-add multiplier started by a register write. All bus responses are OKAY.

---
 rtl/multiplier_proj_pkg.sv | 36 +++
 rtl/mult_seq_core.sv | 82 ++++++++
 rtl/multiplier_proj_axil_slave.sv | 183 ++++++++++++++++++
 tb/tb_multiplier_proj_axil_slave.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_proj_pkg.sv
// Shared constants and types for the multiplier peripheral.
// Holds the byte offsets of the registers, the CTRL/STATUS bit positions,
// the AXI OKAY response, the core state enum and a byte-merge helper.
package multiplier_proj_pkg;

  localparam logic [4:0] OFF_OPA    = 5'h00;
  localparam logic [4:0] OFF_OPB    = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_RES_LO = 5'h10;
  localparam logic [4:0] OFF_RES_HI = 5'h14;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_IE_BIT    = 1;
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned MULT_ITERS = 32;

  typedef enum logic {IDLE, RUN} mult_state_t;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Iterative 32x32 unsigned radix-2 shift-add multiplier.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        one-cycle request; accepted only while idle
//   opa, opb     operands, captured on an accepted start
//   busy         high while iterating
//   done_pulse   high in the final iteration cycle; product updates on that edge
//   product      64-bit result of the most recent completed operation
module mult_seq_core
  import multiplier_proj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done_pulse,
  output logic [63:0] product
);

  mult_state_t state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [63:0] product_q;
  logic [63:0] acc_sum;
  logic        last_iter;

  assign last_iter = (state_q == RUN) && (cnt_q == 6'(MULT_ITERS - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q == RUN);
    done_pulse = last_iter;
  end

  // Datapath: multiplicand shifts left, multiplier shifts right each iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cnt_q    <= '0;
        mcand_q  <= {32'd0, opa};
        mplier_q <= opb;
        acc_q    <= '0;
      end
    end else begin
      cnt_q    <= cnt_q + 6'd1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_sum;
      if (last_iter) product_q <= acc_sum;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/multiplier_proj_axil_slave.sv
// AXI4-Lite register slave for the multiplier peripheral.
// Ports: ACLK/ARESET (async active-high), AXI4-Lite AW/W/B/AR/R channels
// (responses always OKAY), irq = STATUS.done & CTRL.ie.
// Registers: OPA, OPB, CTRL{ie,start}, STATUS{done,busy}, RES_LO, RES_HI.
module multiplier_proj_axil_slave
  import multiplier_proj_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 5,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                ARPROT,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      irq
);

  logic                      aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [C_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_DATA_WIDTH-1:0]   w_data_q, rdata_q, rd_data;
  logic [C_DATA_WIDTH/8-1:0] w_strb_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
  logic [C_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_DATA_WIDTH-1:0]   wr_data;
  logic [C_DATA_WIDTH/8-1:0] wr_strb;

  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        ie_q, ie_d, done_q, done_d, start;
  logic        busy, done_pulse;
  logic [63:0] product;

  assign AWREADY = !aw_held_q && !bvalid_q;
  assign WREADY  = !w_held_q && !bvalid_q;
  assign ARREADY = !rvalid_q;
  assign BVALID  = bvalid_q;
  assign RVALID  = rvalid_q;
  assign BRESP   = RESP_OKAY;
  assign RRESP   = RESP_OKAY;
  assign RDATA   = rdata_q;
  assign irq     = done_q & ie_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = bvalid_q && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = rvalid_q && RREADY;

  // A beat arriving this cycle is used directly so a same-cycle AW+W commits on the next edge.
  assign wr_addr   = aw_held_q ? aw_addr_q : AWADDR;
  assign wr_data   = w_held_q ? w_data_q : WDATA;
  assign wr_strb   = w_held_q ? w_strb_q : WSTRB;
  assign wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

  // Holding registers stay full until the B handshake, which blocks further writes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_commit) bvalid_q <= 1'b1;
      if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // Register file next state
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    ie_d   = ie_q;
    done_d = done_q;
    start  = 1'b0;
    if (wr_commit) begin
      case ({wr_addr[4:2], 2'b00})
        OFF_OPA: opa_d = apply_wstrb(opa_q, wr_data, wr_strb);
        OFF_OPB: opb_d = apply_wstrb(opb_q, wr_data, wr_strb);
        OFF_CTRL: begin
          if (wr_strb[0]) begin
            ie_d  = wr_data[CTRL_IE_BIT];
            start = wr_data[CTRL_START_BIT];
          end
        end
        OFF_STATUS: if (wr_strb[0] && wr_data[STAT_DONE_BIT]) done_d = 1'b0;
        default: ;
      endcase
    end
    // Completion beats a simultaneous clear.
    if (done_pulse) done_d = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      opa_q  <= '0;
      opb_q  <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      ie_q   <= ie_d;
      done_q <= done_d;
    end
  end

  // Read mux on the live AR address; captured at the handshake.
  always_comb begin
    rd_data = '0;
    case ({ARADDR[4:2], 2'b00})
      OFF_OPA:    rd_data = opa_q;
      OFF_OPB:    rd_data = opb_q;
      OFF_CTRL:   rd_data[CTRL_IE_BIT] = ie_q;
      OFF_STATUS: begin
        rd_data[STAT_BUSY_BIT] = busy;
        rd_data[STAT_DONE_BIT] = done_q;
      end
      OFF_RES_LO: rd_data = product[31:0];
      OFF_RES_HI: rd_data = product[63:32];
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  mult_seq_core u_core (
    .clk        (ACLK),
    .rst        (ARESET),
    .start      (start),
    .opa        (opa_q),
    .opb        (opb_q),
    .busy       (busy),
    .done_pulse (done_pulse),
    .product    (product)
  );

  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_multiplier_proj_axil_slave.sv
module tb_multiplier_proj_axil_slave;
  import multiplier_proj_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [4:0]  AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [4:0]  ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        irq;

  multiplier_proj_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int edge_cnt = 0;
  always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [31:0] rq[$];
  logic [1:0]  bq[$];

  // Reference model: register values after a given clock edge.
  logic [31:0] m_opa, m_opb, m_a, m_b;
  logic [63:0] m_res;
  logic        m_ie, m_done, m_busy;
  int          m_fin;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_a = '0; m_b = '0; m_res = '0;
    m_ie = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_fin = 0;
  endtask

  // Bring the model forward to the state just after edge e.
  task automatic model_sync(input int e);
    if (m_busy && m_fin <= e) begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_res  = 64'(m_a) * 64'(m_b);
    end
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int c);
    model_sync(c - 1);
    case (a[4:2])
      3'd0: for (int i = 0; i < 4; i++) if (s[i]) m_opa[8*i +: 8] = d[8*i +: 8];
      3'd1: for (int i = 0; i < 4; i++) if (s[i]) m_opb[8*i +: 8] = d[8*i +: 8];
      3'd2: if (s[0]) begin
        m_ie = d[1];
        if (d[0] && !m_busy) begin
          m_busy = 1'b1;
          m_fin  = c + 32;
          m_a    = m_opa;
          m_b    = m_opb;
        end
      end
      3'd3: if (s[0] && d[1]) m_done = 1'b0;
      default: ;
    endcase
    model_sync(c);
  endtask

  function automatic logic [31:0] model_value(input logic [4:0] a);
    case (a[4:2])
      3'd0: return m_opa;
      3'd1: return m_opb;
      3'd2: return {30'd0, m_ie, 1'b0};
      3'd3: return {30'd0, m_done, m_busy};
      3'd4: return m_res[31:0];
      3'd5: return m_res[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok, w_ok;
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    bq.push_back(RESP_OKAY);
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      if (AWREADY && AWVALID) aw_ok = 1;
      if (WREADY && WVALID) w_ok = 1;
      step();
      if (aw_ok) AWVALID = 1'b0;
      if (w_ok) WVALID = 1'b0;
      n++;
    end
    n = 0;
    while (!BVALID && n < 50) begin
      step();
      n++;
    end
    if (!BVALID) begin
      chk("write_timeout", 1'b0, 1'b1);
      AWVALID = 1'b0; WVALID = 1'b0;
    end else begin
      model_write(a, d, s, edge_cnt);
    end
    step();
  endtask

  task automatic axi_read(input logic [4:0] a);
    int n;
    ARADDR = a; ARVALID = 1'b1; n = 0;
    while (!ARREADY && n < 50) begin
      step();
      n++;
    end
    if (!ARREADY) begin
      chk("read_timeout", 1'b0, 1'b1);
    end else begin
      model_sync(edge_cnt);
      rq.push_back(model_value(a));
    end
    step();
    ARVALID = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("unexpected_b", 1'b1, 1'b0);
        else chk("bresp", BRESP, bq.pop_front());
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) chk("unexpected_r", 1'b1, 1'b0);
        else begin
          chk("rdata", RDATA, rq.pop_front());
          chk("rresp", RRESP, RESP_OKAY);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, AWREADY, 1'b1);
    chk({tag, "_wready"},  WREADY,  1'b1);
    chk({tag, "_arready"}, ARREADY, 1'b1);
    chk({tag, "_bvalid"},  BVALID,  1'b0);
    chk({tag, "_rvalid"},  RVALID,  1'b0);
    chk({tag, "_rdata"},   RDATA,   32'd0);
    chk({tag, "_irq"},     irq,     1'b0);
  endtask

  task automatic chk_irq(input string tag);
    model_sync(edge_cnt);
    chk(tag, irq, m_done & m_ie);
  endtask

  initial begin
    logic [31:0] ra, rb;
    model_reset();
    #2 ARESET = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (3) step();
    ARESET = 1'b0;
    step();

    // 3 x 5 with STATUS polled through the busy window
    axi_write(OFF_OPA, 32'd3, 4'hF);
    axi_write(OFF_OPB, 32'd5, 4'hF);
    axi_write(OFF_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) axi_read(OFF_STATUS);
    axi_read(OFF_RES_LO);
    axi_read(OFF_RES_HI);
    axi_read(OFF_CTRL);

    // all-ones operands with interrupt enabled
    axi_write(OFF_STATUS, 32'h2, 4'hF);
    axi_write(OFF_CTRL, 32'h2, 4'hF);
    axi_write(OFF_OPA, 32'hFFFF_FFFF, 4'hF);
    axi_write(OFF_OPB, 32'hFFFF_FFFF, 4'hF);
    axi_write(OFF_CTRL, 32'h3, 4'hF);
    chk_irq("irq_busy");
    repeat (40) step();
    chk_irq("irq_done");
    axi_read(OFF_RES_HI);
    axi_read(OFF_RES_LO);
    axi_write(OFF_STATUS, 32'h2, 4'hF);
    chk_irq("irq_cleared");

    // W three cycles ahead of AW, BREADY held low
    BREADY = 1'b0;
    WDATA = 32'h1357_9BDF; WSTRB = 4'hF; WVALID = 1'b1;
    bq.push_back(RESP_OKAY);
    step();
    WVALID = 1'b0;
    chk("w_held_wready", WREADY, 1'b0);
    step();
    step();
    AWADDR = OFF_OPB; AWVALID = 1'b1;
    chk("aw_late_awready", AWREADY, 1'b1);
    step();
    AWVALID = 1'b0;
    chk("bvalid_rise", BVALID, 1'b1);
    if (BVALID) model_write(OFF_OPB, 32'h1357_9BDF, 4'hF, edge_cnt);
    for (int i = 0; i < 4; i++) begin
      chk("bvalid_hold", BVALID, 1'b1);
      chk("awready_block", AWREADY, 1'b0);
      step();
    end
    BREADY = 1'b1;
    step();
    chk("bvalid_drop", BVALID, 1'b0);
    chk("awready_back", AWREADY, 1'b1);
    axi_read(OFF_OPB);

    // byte strobes, RO and unmapped slots
    axi_write(OFF_OPA, 32'd0, 4'hF);
    axi_write(OFF_OPA, 32'hAABB_CCDD, 4'b0101);
    axi_read(OFF_OPA);
    axi_write(OFF_RES_LO, 32'hDEAD_BEEF, 4'hF);
    axi_read(OFF_RES_LO);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h1C);
    axi_read(5'h18);
    axi_write(OFF_CTRL, 32'h3, 4'hE);   // no byte 0: neither start nor ie
    axi_read(OFF_STATUS);
    axi_read(OFF_CTRL);

    // restart while busy and operand rewrite mid-run
    axi_write(OFF_OPA, 32'd1000, 4'hF);
    axi_write(OFF_OPB, 32'd2000, 4'hF);
    axi_write(OFF_CTRL, 32'h1, 4'hF);
    axi_write(OFF_CTRL, 32'h1, 4'hF);
    axi_write(OFF_OPA, 32'd5, 4'hF);
    axi_read(OFF_STATUS);
    repeat (40) step();
    axi_read(OFF_RES_LO);
    axi_read(OFF_STATUS);
    axi_write(OFF_STATUS, 32'h2, 4'hF);
    repeat (40) step();
    axi_read(OFF_STATUS);

    // randomized operations with reads at random points
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = $urandom;
      axi_write(OFF_OPA, ra, (k % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      axi_write(OFF_OPB, rb, 4'hF);
      axi_write(OFF_CTRL, {30'd0, 1'($urandom_range(0, 1)), 1'b1}, 4'hF);
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 12)) step();
        axi_read({3'($urandom_range(0, 7)), 2'b00});
      end
      repeat (40) step();
      chk_irq("irq_rand");
      axi_read(OFF_RES_LO);
      axi_read(OFF_RES_HI);
      axi_read(OFF_STATUS);
      axi_write(OFF_STATUS, 32'h2, 4'hF);
    end

    // reset mid-multiply with a read response pending
    axi_write(OFF_OPA, 32'h0001_2345, 4'hF);
    axi_write(OFF_OPB, 32'h0006_7890, 4'hF);
    axi_write(OFF_CTRL, 32'h3, 4'hF);
    repeat (5) step();
    RREADY = 1'b0;
    axi_read(OFF_STATUS);
    chk("rvalid_pending", RVALID, 1'b1);
    #2 ARESET = 1'b1;
    #1 chk_reset_outputs("midreset");
    rq.delete();
    bq.delete();
    model_reset();
    step();
    step();
    ARESET = 1'b0;
    RREADY = 1'b1;
    step();
    axi_read(OFF_STATUS);
    axi_read(OFF_OPA);
    axi_write(OFF_OPA, 32'd7, 4'hF);
    axi_write(OFF_OPB, 32'd6, 4'hF);
    axi_write(OFF_CTRL, 32'h1, 4'hF);
    repeat (40) step();
    axi_read(OFF_RES_LO);
    axi_read(OFF_RES_HI);

    repeat (5) step();
    chk("b_queue_drained", bq.size(), 0);
    chk("r_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
